j1_boot_ctrl: RTL and testbench

Boot sequencer for the j1 core. It holds the core in reset, receives a program image as a byte stream (UART receiver or host FIFO), assembles 16-bit instructions and writes them into code RAM, then releases the core. It sits between the byte source, the write port of the code RAM, and the core's `resetq` input. The core's own fetch port (`code_addr`/`insn`) stays on the RAM read port and is not touched by this block.

---
 rtl/j1_boot_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_j1_boot_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j1_boot_ctrl.sv
// j1_boot_ctrl - boot sequencer for the j1 core.
//
// Holds the core in reset while a program image arrives as a byte stream,
// assembles 16-bit little-endian instructions, writes them into code RAM,
// then releases the core.
//
// Stream: LEN_LO LEN_HI { W_LO W_HI } x LEN [CSUM]
//
// Optional feature macro: J1_BOOT_CHECKSUM_EN
//   When defined, one trailing checksum byte follows the image. The image
//   is accepted when (sum of all data bytes + checksum byte) mod 256 == 0.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-high reset
//   rx_valid     byte available on rx_data
//   rx_data      stream byte
//   rx_ready     block accepts a byte (transfer on rx_valid && rx_ready)
//   boot_req     single-cycle request to restart loading
//   code_we      code RAM write strobe (one cycle per word)
//   code_waddr   code RAM word address
//   code_wdata   instruction word {hi, lo}
//   core_resetq  active-low reset to the j1 core
//   done         image loaded, core running
//   err          load failed, core held in reset
module j1_boot_ctrl #(
  parameter int CODE_AW = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  input  logic               boot_req,
  output logic               code_we,
  output logic [CODE_AW-1:0] code_waddr,
  output logic [15:0]        code_wdata,
  output logic               core_resetq,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    ST_HDR_LO  = 3'd0,
    ST_HDR_HI  = 3'd1,
    ST_DATA_LO = 3'd2,
    ST_DATA_HI = 3'd3,
`ifdef J1_BOOT_CHECKSUM_EN
    ST_CSUM    = 3'd4,
`endif
    ST_RUN     = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  // Largest legal word count: the whole code RAM.
  localparam logic [16:0] MAX_LEN = 17'd1 << CODE_AW;

  state_t             state_r;
  logic [15:0]        len_r;
  logic [7:0]         lo_r;
  logic [CODE_AW-1:0] addr_r;
  // One bit wider than the address so a full-RAM image can be counted.
  logic [CODE_AW:0]   wcnt_r;

  logic               xfer_s;
  logic [15:0]        len_s;
  logic               len_bad_s;
  logic               last_word_s;

  assign xfer_s      = rx_valid && rx_ready;
  assign len_s       = {rx_data, len_r[7:0]};
  assign len_bad_s   = (len_s == 16'd0) || ({1'b0, len_s} > MAX_LEN);
  assign last_word_s = ((16'(wcnt_r) + 16'd1) == len_r);

`ifdef J1_BOOT_CHECKSUM_EN
  logic [7:0] sum_r;
  logic       csum_ok_s;

  // Modulo-256 accumulation of the image checksum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign csum_ok_s = (csum_add(sum_r, rx_data) == 8'd0);
`endif

  // Load sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_HDR_LO;
      len_r       <= 16'd0;
      lo_r        <= 8'd0;
      addr_r      <= '0;
      wcnt_r      <= '0;
      rx_ready    <= 1'b0;
      code_we     <= 1'b0;
      code_waddr  <= '0;
      code_wdata  <= 16'd0;
      core_resetq <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef J1_BOOT_CHECKSUM_EN
      sum_r       <= 8'd0;
`endif
    end else begin
      code_we <= 1'b0;
      if (boot_req) begin
        // Restart wins over any byte offered in the same cycle; RAM contents are left as-is.
        state_r     <= ST_HDR_LO;
        len_r       <= 16'd0;
        addr_r      <= '0;
        wcnt_r      <= '0;
        rx_ready    <= 1'b1;
        core_resetq <= 1'b0;
        done        <= 1'b0;
        err         <= 1'b0;
`ifdef J1_BOOT_CHECKSUM_EN
        sum_r       <= 8'd0;
`endif
      end else begin
        case (state_r)
          ST_HDR_LO: begin
            rx_ready <= 1'b1;
            if (xfer_s) begin
              len_r[7:0] <= rx_data;
              state_r    <= ST_HDR_HI;
            end
          end
          ST_HDR_HI: begin
            rx_ready <= 1'b1;
            if (xfer_s) begin
              len_r <= len_s;
              if (len_bad_s) begin
                state_r  <= ST_ERR;
                err      <= 1'b1;
                rx_ready <= 1'b0;
              end else begin
                addr_r  <= '0;
                wcnt_r  <= '0;
                state_r <= ST_DATA_LO;
`ifdef J1_BOOT_CHECKSUM_EN
                sum_r   <= 8'd0;
`endif
              end
            end
          end
          ST_DATA_LO: begin
            rx_ready <= 1'b1;
            if (xfer_s) begin
              lo_r    <= rx_data;
              state_r <= ST_DATA_HI;
`ifdef J1_BOOT_CHECKSUM_EN
              sum_r   <= csum_add(sum_r, rx_data);
`endif
            end
          end
          ST_DATA_HI: begin
            rx_ready <= 1'b1;
            if (xfer_s) begin
              code_we    <= 1'b1;
              code_waddr <= addr_r;
              code_wdata <= {rx_data, lo_r};
              wcnt_r     <= wcnt_r + (CODE_AW+1)'(1);
`ifdef J1_BOOT_CHECKSUM_EN
              sum_r      <= csum_add(sum_r, rx_data);
`endif
              if (last_word_s) begin
`ifdef J1_BOOT_CHECKSUM_EN
                state_r     <= ST_CSUM;
`else
                // The core restarts at pc=0, so releasing alongside the last write is safe.
                state_r     <= ST_RUN;
                rx_ready    <= 1'b0;
                core_resetq <= 1'b1;
                done        <= 1'b1;
`endif
              end else begin
                // Address only advances between words, so it never wraps past the top.
                addr_r  <= addr_r + CODE_AW'(1);
                state_r <= ST_DATA_LO;
              end
            end
          end
`ifdef J1_BOOT_CHECKSUM_EN
          ST_CSUM: begin
            rx_ready <= 1'b1;
            if (xfer_s) begin
              rx_ready <= 1'b0;
              if (csum_ok_s) begin
                state_r     <= ST_RUN;
                core_resetq <= 1'b1;
                done        <= 1'b1;
              end else begin
                state_r <= ST_ERR;
                err     <= 1'b1;
              end
            end
          end
`endif
          ST_RUN: begin
            rx_ready    <= 1'b0;
            core_resetq <= 1'b1;
            done        <= 1'b1;
          end
          ST_ERR: begin
            rx_ready    <= 1'b0;
            core_resetq <= 1'b0;
            err         <= 1'b1;
          end
          default: begin
            state_r     <= ST_HDR_LO;
            rx_ready    <= 1'b0;
            core_resetq <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_j1_boot_ctrl.sv
// tb_j1_boot_ctrl - self-checking bench for j1_boot_ctrl.
// Streams are generated as byte queues; a stream-level model derives the
// expected RAM writes and final outcome, and a monitor collects the writes
// the block actually issues.
module tb_j1_boot_ctrl;

  localparam int CODE_AW = 13;

  logic               clk = 1'b0;
  logic               reset;
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               rx_ready;
  logic               boot_req;
  logic               code_we;
  logic [CODE_AW-1:0] code_waddr;
  logic [15:0]        code_wdata;
  logic               core_resetq;
  logic               done;
  logic               err;

  j1_boot_ctrl #(.CODE_AW(CODE_AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .boot_req    (boot_req),
    .code_we     (code_we),
    .code_waddr  (code_waddr),
    .code_wdata  (code_wdata),
    .core_resetq (core_resetq),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  stim_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  // Collect every RAM write as {addr, data}.
  always @(negedge clk) begin
    if (code_we === 1'b1) obs_q.push_back((32'(code_waddr) << 16) | 32'(code_wdata));
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream-level model: which words land where, how many bytes are consumed, and the outcome.
  task automatic model(output int consumed, output bit ok);
    int len;
    exp_q.delete();
    len = {stim_q[1], stim_q[0]};
    consumed = 2;
    ok = 1'b0;
    if (len == 0 || len > (1 << CODE_AW)) return;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back((32'(i) << 16) | {16'd0, stim_q[3 + 2*i], stim_q[2 + 2*i]});
      consumed += 2;
    end
    ok = 1'b1;
`ifdef J1_BOOT_CHECKSUM_EN
    begin
      int sum = 0;
      for (int i = 2; i < 2 + 2*len; i++) sum += stim_q[i];
      consumed += 1;
      ok = (((sum + stim_q[2 + 2*len]) % 256) == 0);
    end
`endif
  endtask

  task automatic add_csum(input bit good);
`ifdef J1_BOOT_CHECKSUM_EN
    int sum = 0;
    for (int i = 2; i < stim_q.size(); i++) sum += stim_q[i];
    stim_q.push_back(8'((256 - (sum % 256) + (good ? 0 : $urandom_range(1, 255))) % 256));
`else
    if (good) stim_q = stim_q;
`endif
  endtask

  task automatic gen(input int len_field, input int nwords, input bit good);
    stim_q.delete();
    stim_q.push_back(8'(len_field));
    stim_q.push_back(8'(len_field >> 8));
    for (int i = 0; i < 2*nwords; i++) stim_q.push_back(8'($urandom));
    if (nwords > 0) add_csum(good);
  endtask

  // Offer one byte and return #1 after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int budget = 100;
    while (budget > 0) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      if (rx_ready === 1'b1) begin
        @(posedge clk);
        #1;
        return;
      end
      budget--;
    end
    check("rx_timeout", 32'd0, 32'd1);
  endtask

  task automatic gap();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_boot(input bit with_valid);
    @(negedge clk);
    boot_req = 1'b1;
    rx_valid = with_valid;
    rx_data  = 8'hA5;
    @(posedge clk);
    #1;
    check("boot_rx_ready", 32'(rx_ready), 32'd1);
    check("boot_resetq", 32'(core_resetq), 32'd0);
    check("boot_done_err", {30'd0, done, err}, 32'd0);
    @(negedge clk);
    boot_req = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic run_stream(input bit gaps, input string tag);
    int consumed;
    bit ok;
    int nmis;
    int nobs;
    model(consumed, ok);
    obs_q.delete();
    for (int i = 0; i < consumed; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) gap();
      send_byte(stim_q[i]);
    end
    // State right after the edge that took the final byte.
    if (ok) begin
      check({tag, "_release"}, {29'd0, core_resetq, done, rx_ready}, 32'b110);
`ifndef J1_BOOT_CHECKSUM_EN
      check({tag, "_last_we"}, 32'(code_we), 32'd1);
`endif
    end else begin
      check({tag, "_err"}, {29'd0, err, rx_ready, core_resetq}, 32'b100);
    end
    gap();
    repeat (2) @(negedge clk);
    nobs = obs_q.size();
    // Bytes offered after the image ends must be ignored.
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    check({tag, "_ignored"}, 32'(obs_q.size()), 32'(nobs));
    check({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    nmis = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) nmis++;
    check({tag, "_wr_mismatches"}, 32'(nmis), 32'd0);
    check({tag, "_final"}, {29'd0, done, err, core_resetq}, ok ? 32'b101 : 32'b010);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    boot_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {25'd0, rx_ready, code_we, core_resetq, done, err, 2'b00}, 32'd0);
    check("reset_waddr_wdata", (32'(code_waddr) << 16) | 32'(code_wdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_before_edge", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(rx_ready), 32'd1);

    // Basic two-word image, back-to-back bytes.
    stim_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    add_csum(1'b1);
    run_stream(1'b0, "basic");
    check("basic_word0", exp_q[0], 32'h0000_1234);

    // boot_req in RUN, then reload a single word.
    pulse_boot(1'b0);
    stim_q = '{8'h01, 8'h00, 8'hAA, 8'h55};
    add_csum(1'b1);
    run_stream(1'b1, "reload");
    check("reload_word0", obs_q.size() > 0 ? obs_q[0] : 32'hFFFF_FFFF, 32'h0000_55AA);

    // Zero length.
    pulse_boot(1'b0);
    stim_q = '{8'h00, 8'h00};
    run_stream(1'b0, "len0");
    pulse_boot(1'b1);

    // Oversized length.
    gen(32'h2001, 0, 1'b1);
    run_stream(1'b0, "len2001");

`ifdef J1_BOOT_CHECKSUM_EN
    pulse_boot(1'b0);
    stim_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'hFD};
    run_stream(1'b0, "csum_pass");
    pulse_boot(1'b0);
    stim_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'hFC};
    run_stream(1'b0, "csum_fail");
`endif

    // Restart mid-image: partial writes stay, next load starts at 0.
    pulse_boot(1'b0);
    obs_q.delete();
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    pulse_boot(1'b1);
    check("partial_writes", 32'(obs_q.size()), 32'd1);
    gen(3, 3, 1'b1);
    run_stream(1'b1, "after_partial");

    // Reset pulsed between lo and hi bytes with rx_valid toggling.
    pulse_boot(1'b0);
    obs_q.delete();
    send_byte(8'h01); gap();
    send_byte(8'h00); gap();
    send_byte(8'hAA);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    reset    = 1'b1;
    #1;
    check("midreset_outputs", {27'd0, rx_ready, code_we, core_resetq, done, err}, 32'd0);
    check("midreset_waddr", 32'(code_waddr), 32'd0);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_no_write", 32'(obs_q.size()), 32'd0);
    stim_q = '{8'h01, 8'h00, 8'hAA, 8'h55};
    add_csum(1'b1);
    run_stream(1'b1, "after_reset");

    // Randomised images, including bad lengths and bad checksums.
    for (int it = 0; it < 10; it++) begin
      int kind;
      pulse_boot(1'b0);
      kind = $urandom_range(0, 9);
      if (kind == 0)      gen(0, 0, 1'b1);
      else if (kind == 1) gen($urandom_range(32'h2001, 32'hFFFF), 0, 1'b1);
      else begin
        int n = $urandom_range(1, 24);
        gen(n, n, kind != 2);
      end
      run_stream(1'b1, "random");
    end

    // Full code RAM: 8192 words, last at 0x1FFF.
    pulse_boot(1'b0);
    gen(32'h2000, 32'h2000, 1'b1);
    run_stream(1'b0, "full");
    check("full_last", obs_q.size() > 0 ? obs_q[obs_q.size()-1] >> 16 : 32'hFFFF_FFFF, 32'h1FFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
